// File: rtl/rf_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : rf_pkg
//  Description : Shared defaults, typedefs and constants for the
//                scoreboarded register file.
//  Revision    : 1.0  initial release
// ============================================================================
package rf_pkg;

    localparam int DEFAULT_DATA_W = 32;
    localparam int DEFAULT_ADDR_W = 5;

    typedef logic [DEFAULT_ADDR_W-1:0] reg_addr_t;
    typedef logic [DEFAULT_DATA_W-1:0] reg_data_t;

    localparam reg_addr_t ZERO_ADDR = '0;

endpackage : rf_pkg
`default_nettype wire

// File: rtl/rf_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module      : rf_scoreboard
//  Description : Per-register busy bits with set-over-clear priority and an
//                incrementally maintained count of busy registers.
//  Revision    : 1.0  initial release
// ============================================================================
module rf_scoreboard
    import rf_pkg::*;
#(
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int ZERO_REG = 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   set_en,
    input  logic [ADDR_W-1:0]      set_addr,
    input  logic                   clr_en,
    input  logic [ADDR_W-1:0]      clr_addr,
    output logic [(2**ADDR_W)-1:0] busy,
    output logic [ADDR_W:0]        busy_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [NUM_REGS-1:0] r_busy;
    logic [NUM_REGS-1:0] w_busy_next;
    logic [ADDR_W:0]     r_busy_cnt;
    logic                w_set_ok;
    logic                w_inc;
    logic                w_dec;

    // Issues to the hardwired zero register are dropped so it is never busy.
    assign w_set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));

    // Per-register next state: a new issue beats a same-cycle load return.
    generate
        for (genvar i = 0; i < NUM_REGS; i++) begin : g_bit
            logic w_set;
            logic w_clr;
            assign w_set          = w_set_ok && (set_addr == ADDR_W'(i));
            assign w_clr          = clr_en   && (clr_addr == ADDR_W'(i));
            assign w_busy_next[i] = w_set || (r_busy[i] && !w_clr);
        end
    endgenerate

    // Count moves only when a bit actually changes, so it never wraps.
    assign w_inc = w_set_ok && !r_busy[set_addr];
    assign w_dec = clr_en && r_busy[clr_addr]
                   && !(w_set_ok && (set_addr == clr_addr));

    // Busy vector and its population count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy     <= '0;
            r_busy_cnt <= '0;
        end else begin
            r_busy <= w_busy_next;
            if (w_inc && !w_dec) begin
                r_busy_cnt <= r_busy_cnt + 1'b1;
            end else if (w_dec && !w_inc) begin
                r_busy_cnt <= r_busy_cnt - 1'b1;
            end
        end
    end

    assign busy     = r_busy;
    assign busy_cnt = r_busy_cnt;

endmodule : rf_scoreboard
`default_nettype wire

// File: rtl/register_file_sb.sv
`default_nettype none
// ============================================================================
//  Module      : register_file_sb
//  Description : Multi-read, dual-write CPU register file with optional zero
//                register, same-cycle write bypass and a load scoreboard.
//  Revision    : 1.0  initial release
// ============================================================================
module register_file_sb
    import rf_pkg::*;
#(
    parameter int DATA_W   = DEFAULT_DATA_W,
    parameter int ADDR_W   = DEFAULT_ADDR_W,
    parameter int N_READ   = 2,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [N_READ*ADDR_W-1:0] rd_addr,
    output logic [N_READ*DATA_W-1:0] rd_data,
    output logic [N_READ-1:0]        rd_busy,
    input  logic                     w0_en,
    input  logic [ADDR_W-1:0]        w0_addr,
    input  logic [DATA_W-1:0]        w0_data,
    input  logic                     w1_en,
    input  logic [ADDR_W-1:0]        w1_addr,
    input  logic [DATA_W-1:0]        w1_data,
    input  logic                     issue_en,
    input  logic [ADDR_W-1:0]        issue_addr,
    output logic [ADDR_W:0]          busy_cnt
);

    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0]   r_mem [NUM_REGS];
    logic [NUM_REGS-1:0] w_busy;
    logic                w_w0_ok;
    logic                w_w1_ok;

    assign w_w0_ok = w0_en && !((ZERO_REG != 0) && (w0_addr == '0));
    assign w_w1_ok = w1_en && !((ZERO_REG != 0) && (w1_addr == '0));

    // Storage; W1 is assigned last so it wins an address collision with W0.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_w0_ok) begin
                r_mem[w0_addr] <= w0_data;
            end
            if (w_w1_ok) begin
                r_mem[w1_addr] <= w1_data;
            end
        end
    end

    rf_scoreboard #(
        .ADDR_W   (ADDR_W),
        .ZERO_REG (ZERO_REG)
    ) u_scoreboard (
        .clk      (clk),
        .rst      (rst),
        .set_en   (issue_en),
        .set_addr (issue_addr),
        .clr_en   (w1_en),
        .clr_addr (w1_addr),
        .busy     (w_busy),
        .busy_cnt (busy_cnt)
    );

    // One read/bypass mux per port; bypass is suppressed while in reset so
    // reads follow the cleared state.
    generate
        for (genvar k = 0; k < N_READ; k++) begin : g_read
            logic [ADDR_W-1:0] w_addr;
            logic              w_is_zero;
            logic              w_hit0;
            logic              w_hit1;
            logic              w_hit_issue;

            assign w_addr      = rd_addr[k*ADDR_W +: ADDR_W];
            assign w_is_zero   = (ZERO_REG != 0) && (w_addr == '0);
            assign w_hit0      = (BYPASS != 0) && !rst && w0_en && (w0_addr == w_addr);
            assign w_hit1      = (BYPASS != 0) && !rst && w1_en && (w1_addr == w_addr);
            assign w_hit_issue = issue_en && (issue_addr == w_addr);

            // Data: zero register, then W1 bypass, then W0 bypass, then storage.
            always_comb begin
                rd_data[k*DATA_W +: DATA_W] = r_mem[w_addr];
                if (w_is_zero) begin
                    rd_data[k*DATA_W +: DATA_W] = '0;
                end else if (w_hit1) begin
                    rd_data[k*DATA_W +: DATA_W] = w1_data;
                end else if (w_hit0) begin
                    rd_data[k*DATA_W +: DATA_W] = w0_data;
                end
            end

            // Busy: a returning load clears early unless re-issued this cycle.
            always_comb begin
                rd_busy[k] = w_busy[w_addr];
                if (w_is_zero || (w_hit1 && !w_hit_issue)) begin
                    rd_busy[k] = 1'b0;
                end
            end
        end
    endgenerate

endmodule : register_file_sb
`default_nettype wire
